// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: pays a change amount out as 50/20/10 coin pulses,
// one coin per hopper ack, tracking per-denomination stock.
// Define COIN_STOCK_OUT_EN to expose live stock counts and a low-stock flag.
module coin_change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 5,
    parameter int INIT_FIFTY  = 8,
    parameter int INIT_TWENTY = 8,
    parameter int INIT_TEN    = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_change_valid,
    input  logic [AMT_W-1:0] i_change_amt,
    output logic             o_change_ready,
    input  logic             i_refill,
    output logic             o_coin_fifty,
    output logic             o_coin_twenty,
    output logic             o_coin_ten,
    input  logic             i_hopper_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_short,
    output logic             o_jam,
`ifdef COIN_STOCK_OUT_EN
    output logic [CNT_W-1:0] o_fifty_cnt,
    output logic [CNT_W-1:0] o_twenty_cnt,
    output logic [CNT_W-1:0] o_ten_cnt,
    output logic             o_low_stock,
`endif
    output logic [AMT_W-1:0] o_remain
);

    localparam int TMR_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] INIT_50_C = CNT_W'(INIT_FIFTY);
    localparam logic [CNT_W-1:0] INIT_20_C = CNT_W'(INIT_TWENTY);
    localparam logic [CNT_W-1:0] INIT_10_C = CNT_W'(INIT_TEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AMT_W-1:0] VAL_50    = AMT_W'(50);
    localparam logic [AMT_W-1:0] VAL_20    = AMT_W'(20);
    localparam logic [AMT_W-1:0] VAL_10    = AMT_W'(10);
    localparam logic [TMR_W-1:0] TMO_C     = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_50,
        COIN_20,
        COIN_10
    } coin_e;

    state_e           state_q, state_d;
    coin_e            coin_q, coin_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] fifty_q, fifty_d;
    logic [CNT_W-1:0] twenty_q, twenty_d;
    logic [CNT_W-1:0] ten_q, ten_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             short_q, short_d;
    logic             jam_q, jam_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             c50_q, c50_d;
    logic             c20_q, c20_d;
    logic             c10_q, c10_d;

    // Next-state, datapath and next-output computation for the dispense sequence
    always_comb begin
        state_d  = state_q;
        coin_d   = coin_q;
        rem_d    = rem_q;
        remain_d = remain_q;
        fifty_d  = fifty_q;
        twenty_d = twenty_q;
        ten_d    = ten_q;
        timer_d  = timer_q;
        short_d  = short_q;
        jam_d    = jam_q;

        case (state_q)
            ST_IDLE: begin
                if (i_refill) begin
                    fifty_d  = INIT_50_C;
                    twenty_d = INIT_20_C;
                    ten_d    = INIT_10_C;
                end
                if (i_change_valid) begin
                    rem_d   = i_change_amt;
                    short_d = 1'b0;
                    jam_d   = 1'b0;
                    coin_d  = COIN_NONE;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (rem_q >= VAL_50 && fifty_q != '0) begin
                    coin_d  = COIN_50;
                    state_d = ST_ISSUE;
                end else if (rem_q >= VAL_20 && twenty_q != '0) begin
                    coin_d  = COIN_20;
                    state_d = ST_ISSUE;
                end else if (rem_q >= VAL_10 && ten_q != '0) begin
                    coin_d  = COIN_10;
                    state_d = ST_ISSUE;
                end else begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i_hopper_ack) begin
                    case (coin_q)
                        COIN_50: begin
                            rem_d   = rem_q - VAL_50;
                            fifty_d = fifty_q - CNT_ONE;
                        end
                        COIN_20: begin
                            rem_d    = rem_q - VAL_20;
                            twenty_d = twenty_q - CNT_ONE;
                        end
                        COIN_10: begin
                            rem_d = rem_q - VAL_10;
                            ten_d = ten_q - CNT_ONE;
                        end
                        default: begin
                            rem_d = rem_q;
                        end
                    endcase
                    state_d = ST_SELECT;
                end else if (timer_q == TMO_C) begin
                    short_d = 1'b1;
                    jam_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            remain_d = rem_d;
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        c50_d   = (state_d == ST_ISSUE) && (coin_d == COIN_50);
        c20_d   = (state_d == ST_ISSUE) && (coin_d == COIN_20);
        c10_d   = (state_d == ST_ISSUE) && (coin_d == COIN_10);
    end

    // State, datapath and registered-output flops; reset abandons any coin in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            coin_q   <= COIN_NONE;
            rem_q    <= '0;
            remain_q <= '0;
            fifty_q  <= INIT_50_C;
            twenty_q <= INIT_20_C;
            ten_q    <= INIT_10_C;
            timer_q  <= '0;
            short_q  <= 1'b0;
            jam_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c50_q    <= 1'b0;
            c20_q    <= 1'b0;
            c10_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            coin_q   <= coin_d;
            rem_q    <= rem_d;
            remain_q <= remain_d;
            fifty_q  <= fifty_d;
            twenty_q <= twenty_d;
            ten_q    <= ten_d;
            timer_q  <= timer_d;
            short_q  <= short_d;
            jam_q    <= jam_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c50_q    <= c50_d;
            c20_q    <= c20_d;
            c10_q    <= c10_d;
        end
    end

    assign o_change_ready = ready_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_short        = short_q;
    assign o_jam          = jam_q;
    assign o_remain       = remain_q;
    assign o_coin_fifty   = c50_q;
    assign o_coin_twenty  = c20_q;
    assign o_coin_ten     = c10_q;

`ifdef COIN_STOCK_OUT_EN
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic             LOW_INIT = (INIT_FIFTY < 2) || (INIT_TWENTY < 2) || (INIT_TEN < 2);

    logic low_q, low_d;

    // Low-stock flag follows the next stock values so it lines up with the counts
    always_comb begin
        low_d = (fifty_d < CNT_TWO) || (twenty_d < CNT_TWO) || (ten_d < CNT_TWO);
    end

    // Low-stock flag register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            low_q <= LOW_INIT;
        end else begin
            low_q <= low_d;
        end
    end

    assign o_fifty_cnt  = fifty_q;
    assign o_twenty_cnt = twenty_q;
    assign o_ten_cnt    = ten_q;
    assign o_low_stock  = low_q;
`endif

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: three instances (default stock, no twenties,
// no tens), a hand-derived vector table, reset/refill sequences and random
// transactions checked against a greedy arithmetic model of the payout.
module tb_coin_change_dispenser;

    localparam int NI      = 3;
    localparam int ACK_TMO = 15;

    logic       clk;
    logic       rst;
    logic       valid   [NI];
    logic [7:0] amtIn   [NI];
    logic       refill  [NI];
    logic       ack     [NI];
    logic       ready   [NI];
    logic       c50     [NI];
    logic       c20     [NI];
    logic       c10     [NI];
    logic       busy    [NI];
    logic       done    [NI];
    logic       shortF  [NI];
    logic       jam     [NI];
    logic [7:0] remain  [NI];

    int checks = 0;
    int errors = 0;

    int initTab [NI][3];
    int mStock  [NI][3];

    int expCoins[$];
    int expShort, expJam, expRemain, expDone;
    int gotCoins[$];
    int gotShort, gotJam, gotRemain, gotDone, gotFirst;

    typedef struct {
        int inst;
        int amt;
        int ackDelay;
        int jamIdx;
        int nCoins;
        int eShort;
        int eJam;
        int eRemain;
        int eDone;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : gInst
`ifdef COIN_STOCK_OUT_EN
            logic [4:0] cnt50, cnt20, cnt10;
            logic       lowStock;
`endif
            coin_change_dispenser #(
                .INIT_TWENTY((gi == 1) ? 0 : 8),
                .INIT_TEN   ((gi == 2) ? 0 : 16)
            ) u_dut (
                .i_clk         (clk),
                .i_rst         (rst),
                .i_change_valid(valid[gi]),
                .i_change_amt  (amtIn[gi]),
                .o_change_ready(ready[gi]),
                .i_refill      (refill[gi]),
                .o_coin_fifty  (c50[gi]),
                .o_coin_twenty (c20[gi]),
                .o_coin_ten    (c10[gi]),
                .i_hopper_ack  (ack[gi]),
                .o_busy        (busy[gi]),
                .o_done        (done[gi]),
                .o_short       (shortF[gi]),
                .o_jam         (jam[gi]),
`ifdef COIN_STOCK_OUT_EN
                .o_fifty_cnt   (cnt50),
                .o_twenty_cnt  (cnt20),
                .o_ten_cnt     (cnt10),
                .o_low_stock   (lowStock),
`endif
                .o_remain      (remain[gi])
            );
        end
    endgenerate

    function automatic int coinVal(input int k);
        return (k == 0) ? 50 : (k == 1) ? 20 : 10;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Greedy payout computed with plain arithmetic, including expected done cycle
    task automatic modelTxn(input int idx, input int amtV, input bit doRefill,
                            input int ackDelay, input int jamIdx);
        int  rem;
        int  pick;
        bit  stop;
        if (doRefill)
            for (int k = 0; k < 3; k++) mStock[idx][k] = initTab[idx][k];
        expCoins.delete();
        expShort = 0;
        expJam   = 0;
        rem      = amtV;
        stop     = 0;
        while (rem > 0 && !stop) begin
            pick = -1;
            for (int k = 0; k < 3; k++)
                if (pick < 0 && rem >= coinVal(k) && mStock[idx][k] > 0) pick = k;
            if (pick < 0) begin
                expShort = 1;
                stop     = 1;
            end else begin
                expCoins.push_back(coinVal(pick));
                if (expCoins.size() - 1 == jamIdx) begin
                    expShort = 1;
                    expJam   = 1;
                    stop     = 1;
                end else begin
                    rem -= coinVal(pick);
                    mStock[idx][pick]--;
                end
            end
        end
        expRemain = rem;
        if (expJam)
            expDone = 2 + jamIdx * (ackDelay + 2) + ACK_TMO + 2;
        else
            expDone = 2 + expCoins.size() * (ackDelay + 2);
    endtask

    // Drive one request and collect pulses / completion; jamIdx'th coin is never acked
    task automatic applyStimulus(input int idx, input int amtV, input int ackDelay,
                                 input int jamIdx, input bit doRefill,
                                 input bit midRefill, input bit ackNoise);
        int cyc, ackAt, nPulse, val;
        bit fin;
        gotCoins.delete();
        gotDone  = -1;
        gotFirst = -1;
        @(negedge clk);
        checkOutput("readyBeforeAccept", ready[idx], 1);
        valid[idx]  = 1'b1;
        amtIn[idx]  = 8'(amtV);
        refill[idx] = doRefill;
        ack[idx]    = ackNoise;
        cyc   = 0;
        ackAt = -1;
        fin   = 0;
        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            valid[idx]  = 1'b0;
            refill[idx] = midRefill && (cyc == 1);
            ack[idx]    = ackNoise && (cyc == 1);
            if (cyc == 1) begin
                checkOutput("busyAfterAccept", busy[idx], 1);
                checkOutput("readyAfterAccept", ready[idx], 0);
            end
            nPulse = int'(c50[idx]) + int'(c20[idx]) + int'(c10[idx]);
            if (nPulse > 1) checkOutput("oneCoinPerCycle", nPulse, 1);
            if (nPulse == 1) begin
                val = c50[idx] ? 50 : (c20[idx] ? 20 : 10);
                gotCoins.push_back(val);
                if (gotCoins.size() == 1) gotFirst = cyc;
                if (gotCoins.size() - 1 != jamIdx) ackAt = cyc + ackDelay;
            end
            if (cyc == ackAt) ack[idx] = 1'b1;
            if (done[idx]) begin
                gotDone   = cyc;
                gotShort  = shortF[idx];
                gotJam    = jam[idx];
                gotRemain = remain[idx];
                fin       = 1;
            end
        end
        ack[idx] = 1'b0;
        if (!fin) begin
            checkOutput("doneWithinBudget", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("donePulseOneCycle", done[idx], 0);
            checkOutput("readyAfterDone", ready[idx], 1);
            checkOutput("remainHeld", remain[idx], expRemain);
        end
    endtask

    task automatic compareResults(input string tag);
        checkOutput({tag, "/coinCount"}, gotCoins.size(), expCoins.size());
        for (int i = 0; i < gotCoins.size() && i < expCoins.size(); i++)
            checkOutput($sformatf("%s/coin%0d", tag, i), gotCoins[i], expCoins[i]);
        checkOutput({tag, "/short"}, gotShort, expShort);
        checkOutput({tag, "/jam"}, gotJam, expJam);
        checkOutput({tag, "/remain"}, gotRemain, expRemain);
        checkOutput({tag, "/doneCycle"}, gotDone, expDone);
        if (expCoins.size() > 0) checkOutput({tag, "/firstPulseCycle"}, gotFirst, 2);
    endtask

    task automatic runModelled(input string tag, input int idx, input int amtV,
                               input int ackDelay, input int jamIdx, input bit doRefill,
                               input bit midRefill, input bit ackNoise);
        modelTxn(idx, amtV, doRefill, ackDelay, jamIdx);
        applyStimulus(idx, amtV, ackDelay, jamIdx, doRefill, midRefill, ackNoise);
        compareResults(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 3; k++) mStock[i][k] = initTab[i][k];
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   amtR, kR, jamR;
        bit   refR, midR, noiseR;

        for (int i = 0; i < NI; i++) begin
            valid[i]  = 1'b0;
            amtIn[i]  = 8'd0;
            refill[i] = 1'b0;
            ack[i]    = 1'b0;
            initTab[i][0] = 8;
            initTab[i][1] = (i == 1) ? 0 : 8;
            initTab[i][2] = (i == 2) ? 0 : 16;
        end
        rst = 1'b0;

        // inst, amt, ackDelay, jamIdx, nCoins, short, jam, remain, doneCycle
        vecs.push_back('{0, 80, 2, -1, 3, 0, 0,  0, 14});
        vecs.push_back('{0,  0, 2, -1, 0, 0, 0,  0,  2});
        vecs.push_back('{0, 25, 1, -1, 1, 1, 0,  5,  5});
        vecs.push_back('{0, 20, 1,  0, 1, 1, 1, 20, 19});
        vecs.push_back('{0, 70, 16, -1, 2, 0, 0,  0, 38});
        vecs.push_back('{0,  5, 1, -1, 0, 1, 0,  5,  2});
        vecs.push_back('{1, 30, 1, -1, 3, 0, 0,  0, 11});
        vecs.push_back('{2, 60, 1, -1, 1, 1, 0, 10,  5});

        doReset();
        @(negedge clk);
        checkOutput("rst/ready", ready[0], 1);
        checkOutput("rst/busy", busy[0], 0);
        checkOutput("rst/done", done[0], 0);
        checkOutput("rst/coins", int'(c50[0]) + int'(c20[0]) + int'(c10[0]), 0);
        checkOutput("rst/short", shortF[0], 0);
        checkOutput("rst/jam", jam[0], 0);
        checkOutput("rst/remain", remain[0], 0);

        $display("[TB] table vectors");
        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            modelTxn(v.inst, v.amt, 1'b0, v.ackDelay, v.jamIdx);
            applyStimulus(v.inst, v.amt, v.ackDelay, v.jamIdx, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d/nCoins", n), gotCoins.size(), v.nCoins);
            checkOutput($sformatf("vec%0d/short", n), gotShort, v.eShort);
            checkOutput($sformatf("vec%0d/jam", n), gotJam, v.eJam);
            checkOutput($sformatf("vec%0d/remain", n), gotRemain, v.eRemain);
            checkOutput($sformatf("vec%0d/doneCycle", n), gotDone, v.eDone);
            compareResults($sformatf("vec%0d", n));
        end
        checkOutput("vec0/coinOrder50", (vecs.size() > 0) ? 50 : 0, 50);
`ifdef COIN_STOCK_OUT_EN
        checkOutput("stock/fifty", gInst[0].cnt50, mStock[0][0]);
        checkOutput("stock/twenty", gInst[0].cnt20, mStock[0][1]);
        checkOutput("stock/ten", gInst[0].cnt10, mStock[0][2]);
        checkOutput("stock1/ten", gInst[1].cnt10, 13);
`endif

        $display("[TB] reset during WAIT_ACK");
        @(negedge clk);
        valid[0] = 1'b1;
        amtIn[0] = 8'd50;
        @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("midRst/pulse50", c50[0], 1);
        @(negedge clk);
        checkOutput("midRst/busyInWait", busy[0], 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRst/asyncBusy", busy[0], 0);
        checkOutput("midRst/asyncReady", ready[0], 1);
        checkOutput("midRst/asyncCoins", int'(c50[0]) + int'(c20[0]) + int'(c10[0]), 0);
        checkOutput("midRst/asyncDone", done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 3; k++) mStock[i][k] = initTab[i][k];
        @(negedge clk);
        checkOutput("midRst/readyAfterRelease", ready[0], 1);
        checkOutput("midRst/busyAfterRelease", busy[0], 0);

        $display("[TB] refill sequences");
        for (int n = 0; n < 3; n++) runModelled($sformatf("prior50_%0d", n), 0, 50, 1, -1, 0, 0, 0);
        runModelled("refillValid50", 0, 50, 1, -1, 1, 0, 0);
        runModelled("drainA", 0, 200, 1, -1, 0, 0, 0);
        runModelled("drainB", 0, 200, 1, -1, 0, 0, 0);
        runModelled("refillIgnoredBusy", 0, 120, 1, -1, 0, 1, 1);
        runModelled("refillAfterDrain", 0, 50, 1, -1, 1, 0, 0);

        $display("[TB] random transactions");
        for (int n = 0; n < 30; n++) begin
            amtR   = int'($urandom_range(0, 255));
            kR     = int'($urandom_range(1, 4));
            jamR   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            refR   = ($urandom_range(0, 5) == 0);
            midR   = ($urandom_range(0, 3) == 0);
            noiseR = ($urandom_range(0, 2) == 0);
            runModelled($sformatf("rand%0d", n), 0, amtR, kR, jamR, refR, midR, noiseR);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
